// File: rtl/rv32_alu_pkg.sv
// Shared constants for the ALU issue stage: datapath width, ALU control codes, opcodes.
package rv32_alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/alu_issue_if.sv
// Upstream instruction, forwarding and downstream ALU-side signals of the issue stage.
interface alu_issue_if;
    import rv32_alu_pkg::*;

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never waits on ready, and the slot holds all outputs while out_valid && !out_ready.
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;

    logic            ex_fwd_valid;
    logic            wb_fwd_valid;
    logic [4:0]      ex_fwd_rd;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic [XLEN-1:0] wb_fwd_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] input_a;
    logic [XLEN-1:0] input_b;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd_out;
    logic            illegal;

    modport master (
        output flush, in_valid, opcode, funct3, funct7_5, rs1_addr, rs2_addr,
               rs1_data, rs2_data, imm, rd_addr,
               ex_fwd_valid, wb_fwd_valid, ex_fwd_rd, wb_fwd_rd, ex_fwd_data, wb_fwd_data,
               out_ready,
        input  in_ready, out_valid, input_a, input_b, ctrl, store_data, rd_out, illegal
    );

    modport slave (
        input  flush, in_valid, opcode, funct3, funct7_5, rs1_addr, rs2_addr,
               rs1_data, rs2_data, imm, rd_addr,
               ex_fwd_valid, wb_fwd_valid, ex_fwd_rd, wb_fwd_rd, ex_fwd_data, wb_fwd_data,
               out_ready,
        output in_ready, out_valid, input_a, input_b, ctrl, store_data, rd_out, illegal
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control code, operand-B select and illegal flag.
module alu_ctrl_decode
    import rv32_alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] ctrl,
    output logic       use_imm,
    output logic       illegal
);

    always_comb begin
        ctrl    = ALU_ADD;
        use_imm = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R, OP_IMM: begin
                use_imm = (opcode == OP_IMM);
                case (funct3)
                    // funct7_5 only selects subtract for register-register ops.
                    3'b000:  ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b100:  ctrl = ALU_XOR;
                    3'b110:  ctrl = ALU_OR;
                    3'b111:  ctrl = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: use_imm = 1'b1;
            default:           illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue slot with operand resolution and flush.
// Define FORWARD_EN to enable EX/WB result forwarding; otherwise operands come from the register file.
module alu_issue_stage
    import rv32_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    logic [3:0]      dec_ctrl;
    logic            dec_use_imm;
    logic            dec_illegal;
    logic [XLEN-1:0] rs1_res;
    logic [XLEN-1:0] rs2_res;
    logic            accept;

    logic            out_valid_q;
    logic [XLEN-1:0] input_a_q;
    logic [XLEN-1:0] input_b_q;
    logic [3:0]      ctrl_q;
    logic [XLEN-1:0] store_data_q;
    logic [4:0]      rd_out_q;
    logic            illegal_q;

    alu_ctrl_decode u_decode (
        .opcode   (bus.opcode),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .ctrl     (dec_ctrl),
        .use_imm  (dec_use_imm),
        .illegal  (dec_illegal)
    );

`ifdef FORWARD_EN
    // EX is the younger producer, so it wins over WB; rd 0 never forwards.
    always_comb begin
        if (bus.rs1_addr == 5'd0)
            rs1_res = '0;
        else if (bus.ex_fwd_valid && bus.ex_fwd_rd != 5'd0 && bus.ex_fwd_rd == bus.rs1_addr)
            rs1_res = bus.ex_fwd_data;
        else if (bus.wb_fwd_valid && bus.wb_fwd_rd != 5'd0 && bus.wb_fwd_rd == bus.rs1_addr)
            rs1_res = bus.wb_fwd_data;
        else
            rs1_res = bus.rs1_data;
    end

    always_comb begin
        if (bus.rs2_addr == 5'd0)
            rs2_res = '0;
        else if (bus.ex_fwd_valid && bus.ex_fwd_rd != 5'd0 && bus.ex_fwd_rd == bus.rs2_addr)
            rs2_res = bus.ex_fwd_data;
        else if (bus.wb_fwd_valid && bus.wb_fwd_rd != 5'd0 && bus.wb_fwd_rd == bus.rs2_addr)
            rs2_res = bus.wb_fwd_data;
        else
            rs2_res = bus.rs2_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.ex_fwd_valid, bus.wb_fwd_valid, bus.ex_fwd_rd, bus.wb_fwd_rd,
                          bus.ex_fwd_data, bus.wb_fwd_data};

    assign rs1_res = (bus.rs1_addr == 5'd0) ? '0 : bus.rs1_data;
    assign rs2_res = (bus.rs2_addr == 5'd0) ? '0 : bus.rs2_data;
`endif

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Flush only kills validity; stale operands stay put since nothing downstream looks at them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            input_a_q    <= '0;
            input_b_q    <= '0;
            ctrl_q       <= ALU_ADD;
            store_data_q <= '0;
            rd_out_q     <= '0;
            illegal_q    <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            input_a_q    <= rs1_res;
            input_b_q    <= dec_use_imm ? bus.imm : rs2_res;
            ctrl_q       <= dec_ctrl;
            store_data_q <= rs2_res;
            rd_out_q     <= bus.rd_addr;
            illegal_q    <= dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.input_a    = input_a_q;
    assign bus.input_b    = input_b_q;
    assign bus.ctrl       = ctrl_q;
    assign bus.store_data = store_data_q;
    assign bus.rd_out     = rd_out_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural slot model.
module tb_alu_issue_stage;
  import rv32_alu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [3:0]  ec;
    logic [31:0] esd;
    logic        ei;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        ill;
  } slot_t;

  vec_t  vecs[12];
  slot_t model;

  // scoreboard helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rs1a, input logic [31:0] rs1d,
                             input logic [4:0] rs2a, input logic [31:0] rs2d,
                             input logic [31:0] imm, input logic [4:0] rd);
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.rs1_addr = rs1a;
    bus.rs1_data = rs1d;
    bus.rs2_addr = rs2a;
    bus.rs2_data = rs2d;
    bus.imm      = imm;
    bus.rd_addr  = rd;
  endtask

  task automatic drive_fwd(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                           input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd);
    bus.ex_fwd_valid = exv;
    bus.ex_fwd_rd    = exrd;
    bus.ex_fwd_data  = exd;
    bus.wb_fwd_valid = wbv;
    bus.wb_fwd_rd    = wbrd;
    bus.wb_fwd_data  = wbd;
  endtask

  task automatic chk_outputs(input string tag, input slot_t s);
    chk({tag, ".out_valid"},  bus.out_valid,  s.valid);
    chk({tag, ".input_a"},    bus.input_a,    s.a);
    chk({tag, ".input_b"},    bus.input_b,    s.b);
    chk({tag, ".ctrl"},       bus.ctrl,       s.c);
    chk({tag, ".store_data"}, bus.store_data, s.sd);
    chk({tag, ".rd_out"},     bus.rd_out,     s.rd);
    chk({tag, ".illegal"},    bus.illegal,    s.ill);
  endtask

  // reference model: spec rules written as plain arithmetic
  function automatic logic [31:0] ref_resolve(input logic [4:0] idx, input logic [31:0] rf);
    logic [31:0] r;
    r = rf;
`ifdef FORWARD_EN
    if (bus.wb_fwd_valid && bus.wb_fwd_rd == idx) r = bus.wb_fwd_data;
    if (bus.ex_fwd_valid && bus.ex_fwd_rd == idx) r = bus.ex_fwd_data;
`endif
    if (idx == 5'd0) r = 32'd0;
    return r;
  endfunction

  function automatic slot_t ref_accept();
    slot_t s;
    logic  is_ri;
    logic  legal_f3;
    logic [31:0] r1;
    logic [31:0] r2;
    r1 = ref_resolve(bus.rs1_addr, bus.rs1_data);
    r2 = ref_resolve(bus.rs2_addr, bus.rs2_data);
    is_ri    = (bus.opcode == 7'h33) || (bus.opcode == 7'h13);
    legal_f3 = (bus.funct3 == 3'd0) || (bus.funct3 >= 3'd6) || (bus.funct3 == 3'd4);
    s.valid = 1'b1;
    s.a     = r1;
    s.sd    = r2;
    s.rd    = bus.rd_addr;
    s.ill   = is_ri ? !legal_f3 : !(bus.opcode == 7'h03 || bus.opcode == 7'h23);
    s.b     = (bus.opcode == 7'h33 || s.ill && !is_ri) ? r2 : bus.imm;
    if (is_ri && legal_f3)
      s.c = {(bus.opcode == 7'h33 && bus.funct3 == 3'd0 && bus.funct7_5), bus.funct3};
    else
      s.c = 4'd0;
    return s;
  endfunction

  slot_t exp_s;
  logic [31:0] fwd_exp;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive_instr(7'd0, 3'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    step();

    // reset state
    exp_s = '{1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b0};
    chk_outputs("reset", exp_s);
    chk("reset.in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;

    // vector table
    vecs[0]  = '{7'h33, 3'b000, 1'b1, 5'd1, 32'd10,        5'd2, 32'd3,      32'd0,
                 32'd10, 32'd3, 4'b1000, 32'd3, 1'b0};
    vecs[1]  = '{7'h33, 3'b000, 1'b0, 5'd1, 32'd100,       5'd2, 32'd23,     32'd5,
                 32'd100, 32'd23, 4'b0000, 32'd23, 1'b0};
    vecs[2]  = '{7'h13, 3'b100, 1'b0, 5'd3, 32'hFF00FF00,  5'd4, 32'h1234,   32'hFFFFFFFF,
                 32'hFF00FF00, 32'hFFFFFFFF, 4'b0100, 32'h1234, 1'b0};
    vecs[3]  = '{7'h13, 3'b000, 1'b1, 5'd3, 32'd7,         5'd4, 32'd9,      32'hFFFFFFF0,
                 32'd7, 32'hFFFFFFF0, 4'b0000, 32'd9, 1'b0};
    vecs[4]  = '{7'h33, 3'b110, 1'b0, 5'd6, 32'hF0,        5'd7, 32'h0F,     32'h77,
                 32'hF0, 32'h0F, 4'b0110, 32'h0F, 1'b0};
    vecs[5]  = '{7'h13, 3'b111, 1'b1, 5'd6, 32'hAA,        5'd7, 32'd1,      32'h55,
                 32'hAA, 32'h55, 4'b0111, 32'd1, 1'b0};
    vecs[6]  = '{7'h03, 3'b010, 1'b0, 5'd8, 32'h1000,      5'd9, 32'd5,      32'h20,
                 32'h1000, 32'h20, 4'b0000, 32'd5, 1'b0};
    vecs[7]  = '{7'h23, 3'b010, 1'b0, 5'd8, 32'h2000,      5'd9, 32'hDEAD,   32'h8,
                 32'h2000, 32'h8, 4'b0000, 32'hDEAD, 1'b0};
    vecs[8]  = '{7'h63, 3'b000, 1'b0, 5'd1, 32'd5,         5'd2, 32'd6,      32'h10,
                 32'd5, 32'd6, 4'b0000, 32'd6, 1'b1};
    vecs[9]  = '{7'h33, 3'b001, 1'b0, 5'd1, 32'd11,        5'd2, 32'd12,     32'h10,
                 32'd11, 32'd12, 4'b0000, 32'd12, 1'b1};
    vecs[10] = '{7'h13, 3'b101, 1'b1, 5'd1, 32'd13,        5'd2, 32'd14,     32'h44,
                 32'd13, 32'h44, 4'b0000, 32'd14, 1'b1};
    vecs[11] = '{7'h33, 3'b100, 1'b0, 5'd0, 32'hBAD,       5'd0, 32'hBEEF,   32'd0,
                 32'd0, 32'd0, 4'b0100, 32'd0, 1'b0};

    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1a, vecs[i].rs1d,
                  vecs[i].rs2a, vecs[i].rs2d, vecs[i].imm, 5'(i + 1));
      step();
      exp_s = '{1'b1, vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].esd, 5'(i + 1), vecs[i].ei};
      chk_outputs($sformatf("vec%0d", i), exp_s);
    end

    // stall: hold out_ready low, upstream keeps offering, forwarding inputs wiggle
    drive_instr(7'h33, 3'b000, 1'b1, 5'd1, 32'd50, 5'd2, 32'd20, 32'd0, 5'd3);
    step();
    exp_s = '{1'b1, 32'd50, 32'd20, 4'b1000, 32'd20, 5'd3, 1'b0};
    bus.out_ready = 1'b0;
    drive_instr(7'h13, 3'b110, 1'b0, 5'd4, 32'h0F0F, 5'd5, 32'd1, 32'h3000, 5'd9);
    for (int k = 0; k < 3; k++) begin
      drive_fwd(1'b1, 5'd1, 32'(k + 77), 1'b1, 5'd2, 32'(k + 88));
      #1;
      chk($sformatf("stall%0d.in_ready", k), bus.in_ready, 1'b0);
      step();
      chk_outputs($sformatf("stall%0d", k), exp_s);
    end
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", bus.in_ready, 1'b1);
    step();
    exp_s = '{1'b1, 32'h0F0F, 32'h3000, 4'b0110, 32'd1, 5'd9, 1'b0};
    chk_outputs("unstall", exp_s);

    // forwarding priority and rd 0
    drive_instr(7'h33, 3'b000, 1'b0, 5'd5, 32'h99, 5'd7, 32'h66, 32'd0, 5'd1);
    drive_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
    step();
`ifdef FORWARD_EN
    fwd_exp = 32'h11;
`else
    fwd_exp = 32'h99;
`endif
    chk("fwd_ex.input_a", bus.input_a, fwd_exp);
    drive_fwd(1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
    step();
`ifdef FORWARD_EN
    fwd_exp = 32'h22;
`else
    fwd_exp = 32'h99;
`endif
    chk("fwd_wb.input_a", bus.input_a, fwd_exp);
    drive_instr(7'h23, 3'b010, 1'b0, 5'd0, 32'h44, 5'd7, 32'h66, 32'h4, 5'd0);
    drive_fwd(1'b1, 5'd0, 32'h33, 1'b1, 5'd7, 32'h55);
    step();
`ifdef FORWARD_EN
    fwd_exp = 32'h55;
`else
    fwd_exp = 32'h66;
`endif
    chk("fwd_rd0.input_a", bus.input_a, 32'd0);
    chk("fwd_rs2.store_data", bus.store_data, fwd_exp);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // flush with an illegal instruction held and a new one offered
    drive_instr(7'h63, 3'b000, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd4);
    step();
    chk("pre_flush.illegal", bus.illegal, 1'b1);
    chk("pre_flush.out_valid", bus.out_valid, 1'b1);
    bus.flush = 1'b1;
    bus.out_ready = 1'b0;
    drive_instr(7'h33, 3'b000, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd5);
    step();
    chk("flush.out_valid", bus.out_valid, 1'b0);
    chk("flush.illegal", bus.illegal, 1'b0);
    bus.flush = 1'b0;

    // consume with no new offer drains the slot
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("drain.out_valid", bus.out_valid, 1'b0);

    // reset while stalled
    bus.in_valid = 1'b1;
    drive_instr(7'h33, 3'b111, 1'b0, 5'd3, 32'h1234, 5'd4, 32'h5678, 32'd0, 5'd6);
    step();
    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_s = '{1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b0};
    chk_outputs("rst_stall", exp_s);
    #1;
    chk("rst_stall.in_ready", bus.in_ready, 1'b1);

    // randomized traffic against the slot model
    model = '{1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b0};
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ops[5];
      logic exp_ready;
      ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
      ops[4] = 7'($urandom_range(0, 127));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      drive_instr(ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                  $urandom, 5'($urandom_range(0, 31)));
      drive_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      #1;
      exp_ready = !model.valid || bus.out_ready;
      chk("rand.in_ready", bus.in_ready, exp_ready);
      if (bus.flush) begin
        model.valid = 1'b0;
        model.ill   = 1'b0;
      end else if (bus.in_valid && exp_ready) begin
        model = ref_accept();
      end else if (bus.out_ready) begin
        model.valid = 1'b0;
      end
      step();
      chk_outputs($sformatf("rand%0d", n), model);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
